demo_diagnostic_pio_sequencer: RTL

//  Autonomous pattern sequencer for the 8-bit diagnostic output PIO (s1: 0=DATA, 4=OUTSET, 5=OUTCLR).
//  CPU loads a table of steps over an Avalon-MM CSR slave and starts it.

---
 rtl/demo_diagnostic_pio_pkg.sv | 36 +++
 rtl/demo_diagnostic_seq_table.sv | 31 +++
 rtl/demo_diagnostic_pio_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/demo_diagnostic_pio_pkg.sv
// Shared constants and types for the diagnostic PIO pattern sequencer:
// PIO register offsets, table op codes, CSR word map and the sequencer FSM states.
package demo_diagnostic_pio_pkg;

   localparam logic [2:0] PIO_DATA   = 3'd0;
   localparam logic [2:0] PIO_OUTSET = 3'd4;
   localparam logic [2:0] PIO_OUTCLR = 3'd5;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_SET   = 2'd1;
   localparam logic [1:0] OP_CLEAR = 2'd2;
   localparam logic [1:0] OP_HOLD  = 2'd3;

   localparam logic [2:0] CSR_CTRL   = 3'd0;
   localparam logic [2:0] CSR_STATUS = 3'd1;
   localparam logic [2:0] CSR_PERIOD = 3'd2;
   localparam logic [2:0] CSR_LAST   = 3'd3;
   localparam logic [2:0] CSR_TPTR   = 3'd4;
   localparam logic [2:0] CSR_TDATA  = 3'd5;

   // The step decision between two strobes is combinational, so it has no state.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } seq_state_t;

   function automatic logic [2:0] op_to_pio(input logic [1:0] op);
      case (op)
         OP_SET:   return PIO_OUTSET;
         OP_CLEAR: return PIO_OUTCLR;
         default:  return PIO_DATA;
      endcase
   endfunction

endpackage

// File: rtl/demo_diagnostic_seq_table.sv
// Step table: DEPTH x 10-bit register file, one write port, two asynchronous read
// ports (CSR readback and sequencer fetch), cleared by reset.
module demo_diagnostic_seq_table #(
   parameter int DEPTH = 8,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  logic [9:0]    wdata,
   input  logic [IW-1:0] raddr_csr,
   output logic [9:0]    rdata_csr,
   input  logic [IW-1:0] raddr_seq,
   output logic [9:0]    rdata_seq
);

   logic [9:0] mem [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_csr = mem[raddr_csr];
   assign rdata_seq = mem[raddr_seq];

endmodule

// File: rtl/demo_diagnostic_pio_sequencer.sv
// Plays a CPU-loaded table of LED steps onto the diagnostic PIO s1 port, one
// write strobe every PERIOD clocks, optionally looping, without CPU involvement.
module demo_diagnostic_pio_sequencer
   import demo_diagnostic_pio_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int PERIOD_W = 24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [2:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata
);

   localparam int IW = $clog2(DEPTH);

   // Handshake: neither Avalon port has waitrequest. A CSR write is accepted in the
   // cycle s_chipselect & ~s_write_n is high; a PIO write completes in the single
   // cycle m_chipselect is high, so every strobe is exactly one clock long.
   seq_state_t          state, state_n;
   logic [IW-1:0]       index, index_n, last_r, tptr;
   logic [PERIOD_W-1:0] period_r, cnt, cnt_n;
   logic                done, done_set, loop_r, advance;
   logic                csr_wr, start_p, stop_p, strobe;
   logic [9:0]          entry_seq, entry_csr;
   logic                unused_wd;

   assign csr_wr    = s_chipselect & ~s_write_n;
   assign start_p   = csr_wr && (s_address == CSR_CTRL) && s_writedata[0];
   assign stop_p    = csr_wr && (s_address == CSR_CTRL) && s_writedata[2];
   assign unused_wd = ^s_writedata;

   demo_diagnostic_seq_table #(.DEPTH(DEPTH), .IW(IW)) u_table (
      .clk       (clk),
      .reset_n   (reset_n),
      .we        (csr_wr && (s_address == CSR_TDATA)),
      .waddr     (tptr),
      .wdata     (s_writedata[9:0]),
      .raddr_csr (tptr),
      .rdata_csr (entry_csr),
      .raddr_seq (index),
      .rdata_seq (entry_seq)
   );

   always_comb begin
      state_n  = state;
      index_n  = index;
      cnt_n    = cnt;
      done_set = 1'b0;
      advance  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_p) begin
               index_n = '0;
               state_n = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (period_r <= PERIOD_W'(1)) begin
               advance = 1'b1;
            end else begin
               cnt_n   = period_r - PERIOD_W'(2);
               state_n = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt == '0) advance = 1'b1;
            else           cnt_n   = cnt - PERIOD_W'(1);
         end
         default: state_n = ST_IDLE;
      endcase
      if (advance) begin
         if (index != last_r) begin
            index_n = index + IW'(1);
            state_n = ST_ISSUE;
         end else if (loop_r) begin
            index_n = '0;
            state_n = ST_ISSUE;
         end else begin
            done_set = 1'b1;
            state_n  = ST_IDLE;
         end
      end
      // Stop overrides everything, including a start in the same write, and never sets done.
      if (stop_p) begin
         state_n  = ST_IDLE;
         index_n  = index;
         done_set = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         index    <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         loop_r   <= 1'b0;
         period_r <= PERIOD_W'(1);
         last_r   <= IW'(DEPTH - 1);
         tptr     <= '0;
      end else begin
         state <= state_n;
         index <= index_n;
         cnt   <= cnt_n;
         if (done_set) done <= 1'b1;
         else if (csr_wr && (s_address == CSR_STATUS) && s_writedata[1]) done <= 1'b0;
         if (csr_wr) begin
            case (s_address)
               CSR_CTRL:   loop_r   <= s_writedata[1];
               CSR_PERIOD: period_r <= s_writedata[PERIOD_W-1:0];
               CSR_LAST:   last_r   <= s_writedata[IW-1:0];
               CSR_TPTR:   tptr     <= s_writedata[IW-1:0];
               CSR_TDATA:  tptr     <= tptr + IW'(1);
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      s_readdata = '0;
      case (s_address)
         CSR_CTRL:   s_readdata[1] = loop_r;
         CSR_STATUS: begin
            s_readdata[0]       = (state != ST_IDLE);
            s_readdata[1]       = done;
            s_readdata[4 +: IW] = index;
         end
         CSR_PERIOD: s_readdata[PERIOD_W-1:0] = period_r;
         CSR_LAST:   s_readdata[IW-1:0]       = last_r;
         CSR_TPTR:   s_readdata[IW-1:0]       = tptr;
         CSR_TDATA:  s_readdata[9:0]          = entry_csr;
         default: ;
      endcase
   end

   // Master outputs decode only registered state and table contents, so reset drops them at once.
   assign strobe       = (state == ST_ISSUE) && (entry_seq[9:8] != OP_HOLD);
   assign m_chipselect = strobe;
   assign m_write_n    = ~strobe;
   assign m_address    = strobe ? op_to_pio(entry_seq[9:8]) : 3'd0;
   assign m_writedata  = strobe ? {24'b0, entry_seq[7:0]} : 32'd0;

endmodule
